// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract unit: one 4-bit carry-lookahead slice per clock, LSB nibble first,
// with the slice carry registered between nibbles and a start/done handshake.

module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4,
   localparam int unsigned WIDTH = 4 * NIBBLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   // 4-bit carry-lookahead slice operating on the currently selected nibble
   logic [3:0] x, y, g, p, f;
   logic [4:0] c;

   always_comb begin
      x    = 4'(a_q >> {idx_q, 2'b00});
      y    = 4'(b_q >> {idx_q, 2'b00});
      g    = x & y;
      p    = x ^ y;
      c[0] = carry_q;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      f    = p ^ c[3:0];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               // Subtraction is folded into A + ~B + 1 so the slice only ever adds
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d   = (sum_q & ~(WIDTH'(4'hF) << {idx_q, 2'b00}))
                    | (WIDTH'(f) << {idx_q, 2'b00});
            carry_d = c[4];
            if (idx_q == LAST_IDX) begin
               // f[3] is the result MSB being written on this same edge
               cout_d  = c[4];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (f[3] != a_q[WIDTH-1]);
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed literal cases plus randomized traffic checked every
// cycle against an arithmetic model of the operation timeline.

module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst, start, cin, sub;
   logic [W-1:0] a, b, sum;
   logic         busy, done, cout, ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
      int sx, sy, r;
      sx = int'($signed(x));
      sy = int'($signed(y));
      r  = s ? (sx - sy) : (sx + sy + int'(c));
      return (r > 32767) || (r < -32768);
   endfunction

   // Model: k = 0 idle, 1..N busy cycles, N+1 done cycle
   int           k = 0;
   bit           armed = 1'b0;
   bit           sum_known = 1'b0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0, m_ovf = 1'b0;
   logic [W:0]   p_res;
   logic         p_ovf;
   logic [W-1:0] bp;

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         k = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; sum_known = 1'b1; armed = 1'b1;
      end else if (k == 0) begin
         if (start === 1'b1) begin
            bp    = sub ? ~b : b;
            p_res = {1'b0, a} + {1'b0, bp} + (W + 1)'(sub ? 1'b1 : cin);
            p_ovf = signed_ovf(a, b, cin, sub);
            k     = 1;
         end
      end else if (k <= N) begin
         if (k == 1) sum_known = 1'b0;
         k++;
         if (k == N + 1) begin
            m_sum = p_res[W-1:0]; m_cout = p_res[W]; m_ovf = p_ovf; sum_known = 1'b1;
         end
      end else begin
         k = 0;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("model busy", busy, (k >= 1 && k <= N));
         chk("model done", done, (k == N + 1));
         chk("model cout", cout, m_cout);
         chk("model ovf", ovf, m_ovf);
         if (sum_known) chk("model sum", sum, m_sum);
      end
   end

   task automatic do_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input logic [W-1:0] es,
                        input logic ec, input logic eo);
      int cnt;
      @(negedge clk);
      a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      cnt = 1;
      while (done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk({name, " latency"}, cnt, N + 1);
      chk({name, " sum"}, sum, es);
      chk({name, " cout"}, cout, ec);
      chk({name, " ovf"}, ovf, eo);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int ndone;
      int cnt;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset sum", sum, 0);
      chk("reset cout", cout, 0);
      chk("reset ovf", ovf, 0);
      rst = 1'b0;

      do_op("add 1234+4321", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
      do_op("add 0fff+1",    16'h0FFF, 16'h0001, 0, 0, 16'h1000, 0, 0);
      do_op("add ffff+1",    16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
      do_op("add 0+0+cin",   16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0);
      do_op("add 7fff+1",    16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
      do_op("add 8000+8000", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
      do_op("sub 5-7",       16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
      do_op("sub 8000-1",    16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
      do_op("sub 1234-1234", 16'h1234, 16'h1234, 0, 1, 16'h0000, 1, 0);

      // start re-asserted mid-run with different operands
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
      ndone = 0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            chk("restart sum", sum, 16'h3333);
         end
         start = (cyc == 2 || cyc == 3);
         a = start ? 16'hFFFF : W'($urandom);
         b = start ? 16'hFFFF : W'($urandom);
      end
      chk("restart done count", ndone, 1);

      // start in the DONE cycle ignored, accepted in the following IDLE cycle
      @(negedge clk);
      a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 1;
      while (done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("done-cycle sum", sum, 16'h0300);
      a = 16'h0003; b = 16'h0004; start = 1'b1;
      @(negedge clk);
      chk("done-cycle start ignored", busy, 0);
      a = 16'h0010; b = 16'h0020;
      @(negedge clk);
      start = 1'b0;
      chk("idle start accepted", busy, 1);
      cnt = 1;
      while (done !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("idle start sum", sum, 16'h0030);

      // reset during RUN at idx 2, with start held alongside reset
      @(negedge clk);
      a = 16'hABCD; b = 16'h1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("midreset busy", busy, 0);
      chk("midreset done", done, 0);
      chk("midreset sum", sum, 0);
      chk("midreset cout", cout, 0);
      chk("midreset ovf", ovf, 0);
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("midreset no done", ndone, 0);
      do_op("after reset 1+2", 16'h0001, 16'h0002, 0, 0, 16'h0003, 0, 0);

      // random traffic with occasional resets; the compare process checks every cycle
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         a     = pick();
         b     = pick();
         cin   = 1'($urandom);
         sub   = 1'($urandom);
         rst   = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit that drives the existing 4-bit carry-lookahead slice (CLAA: X[3:0], Y[3:0], C0 -> F[3:0], C4).
- Processes one nibble per clock, LSB nibble first, and registers the slice carry between nibbles.
- Upstream driver of the CLA slice; gives the datapath a 16-bit adder with a start/done handshake, carry-out and signed overflow.

Parameters:
- NIBBLES, 4, number of 4-bit slices processed; operand width WIDTH = 4*NIBBLES.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute a - b; captured with operands.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry out of MSB nibble; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry reg=0, operand regs=0, busy=0, done=0, sum=0, cout=0, ovf=0. Reset overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch A=a and B'=(sub ? ~b : b).
  - Set carry reg = (sub ? 1 : cin), idx=0, go to RUN.
  - sum, cout and ovf hold their previous values until the first RUN edge.
- RUN (one nibble per cycle):
  - Drive the slice with X=A[4*idx+3:4*idx], Y=B'[4*idx+3:4*idx], C0=carry reg.
  - On each edge: sum[4*idx+3:4*idx] <= F; carry reg <= C4.
  - If idx==NIBBLES-1: go to DONE. Otherwise idx <= idx+1.
  - sum is partially updated during RUN and is valid only from the DONE cycle.
- DONE:
  - done=1 for exactly this cycle; cout=carry reg.
  - ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]).
  - Next edge returns to IDLE.
  - cout and ovf are registered on the RUN->DONE edge. They are visible in the DONE cycle and held after it.
- Latency:
  - Start accepted at edge 0; done is high in the cycle following edge NIBBLES (4 for the default).
  - Next start is accepted no earlier than the IDLE cycle after DONE. Throughput is one operation per NIBBLES+2 cycles.
- start while RUN or DONE: ignored, with no queuing. Operands changing after acceptance have no effect.
- Arithmetic:
  - Unsigned result is {cout, sum} = A + B' + C0_initial, modulo 2^(WIDTH+1).
  - Subtraction is A + ~B + 1.
- Result hold: sum, cout and ovf remain stable in IDLE until the next accepted start's first RUN edge.
- Reset mid-operation:
  - Aborts the operation; no done pulse is produced.
  - All outputs return to 0 on the reset edge.
  - start asserted in the same cycle as rst is ignored.
- Carry chain: the carry reg is the only inter-nibble path. No combinational path exists from a, b, cin or sub to any output.

Test Plan:
- Add, no carry: a=0x1234, b=0x4321, cin=0, sub=0, start pulse -> busy high 4 cycles; done in cycle 5 after start edge; sum=0x5555, cout=0, ovf=0.
- Inter-nibble ripple and wrap: 0x0FFF+0x0001 -> sum=0x1000, cout=0. Then 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0. Then 0x0000+0x0000 with cin=1 -> sum=0x0001.
- Signed overflow:
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract:
  - 0x0005-0x0007 with cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x1234-0x1234 -> sum=0x0000, cout=1.
- Handshake robustness:
  - Start 0x1111+0x2222, then re-assert start with 0xFFFF+0xFFFF on cycles 2 and 3 and change a/b mid-run -> result 0x3333, exactly one done pulse.
  - Start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- Reset mid-op:
  - Start 0xABCD+0x1111, assert rst for one cycle at RUN idx=2 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, and no done pulse follows.
  - A subsequent 0x0001+0x0002 gives sum=0x0003.
